// File: rtl/lif_membrane_integrator.sv
// Leaky integrate-and-fire membrane stage: accumulates signed weights with shift leak, fires on cmp_ge.
// Latency: accepted weight/leak visible on membrane after one edge; spike one edge after cmp_ge rises.
// Backpressure: in_ready high only while integrating and enabled; weights offered on a fire cycle are dropped.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   ena                 stage enable; low freezes all state
//   in_valid/in_weight  signed synaptic weight with its valid; in_ready is the handshake
//   leak_tick           apply one leak step (membrane -= membrane >> LEAK_SHIFT)
//   cmp_ge              threshold comparator result (GT|EQ), combinational from membrane
//   membrane            registered membrane potential, comparator A operand
//   spike               registered one-cycle fire pulse
//   refractory          high in FIRE and REFRACT
//   spike_count         saturating count of spikes emitted
module lif_membrane_integrator #(
    parameter int               WIDTH      = 8,
    parameter int               LEAK_SHIFT = 3,
    parameter int               REFRACT    = 4,
    parameter logic [WIDTH-1:0] RESET_V    = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_weight,
    output logic             in_ready,
    input  logic             leak_tick,
    input  logic             cmp_ge,
    output logic [WIDTH-1:0] membrane,
    output logic             spike,
    output logic             refractory,
    output logic [7:0]       spike_count
);

    typedef enum logic [1:0] {
        ST_INTEGRATE = 2'd0,
        ST_FIRE      = 2'd1,
        ST_REFRACT   = 2'd2
    } state_t;

    localparam logic [3:0] REFRACT_L = 4'(REFRACT);

    state_t                 state_q, state_d;
    logic [3:0]             rcnt_q, rcnt_d;
    logic [WIDTH-1:0]       mem_d;
    logic [7:0]             cnt_d;
    logic                   spike_d;

    logic [WIDTH-1:0]       leaked;
    logic [WIDTH-1:0]       base;
    logic signed [WIDTH+1:0] sum;
    logic [WIDTH-1:0]       clamped;
    logic                   accept;

    assign in_ready   = ena && (state_q == ST_INTEGRATE);
    assign refractory = (state_q != ST_INTEGRATE);

    // cmp_ge has priority over acceptance: a fire cycle discards the offered weight
    assign accept = in_valid && in_ready && !cmp_ge;

    // Leak is applied before the weight add; with LEAK_SHIFT=0 the leak empties the membrane
    assign leaked = membrane - (membrane >> LEAK_SHIFT);
    assign base   = leak_tick ? leaked : membrane;

    // Two guard bits make the sum a signed value that cannot overflow: range is -128 .. 382
    assign sum = $signed({2'b00, base}) + $signed({{2{in_weight[WIDTH-1]}}, in_weight});

    always_comb begin
        clamped = sum[WIDTH-1:0];
        if (sum[WIDTH+1]) begin
            clamped = '0;
        end else if (sum[WIDTH]) begin
            clamped = '1;
        end
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        mem_d   = membrane;
        cnt_d   = spike_count;
        if (ena) begin
            case (state_q)
                ST_INTEGRATE: begin
                    if (cmp_ge) begin
                        state_d = ST_FIRE;
                        mem_d   = RESET_V;
                        rcnt_d  = REFRACT_L;
                        if (spike_count != 8'hFF) begin
                            cnt_d = spike_count + 8'd1;
                        end
                    end else if (accept) begin
                        mem_d = clamped;
                    end else begin
                        mem_d = base;
                    end
                end
                ST_FIRE: begin
                    mem_d   = RESET_V;
                    state_d = (REFRACT_L != 4'd0) ? ST_REFRACT : ST_INTEGRATE;
                end
                ST_REFRACT: begin
                    mem_d  = RESET_V;
                    rcnt_d = rcnt_q - 4'd1;
                    if (rcnt_q == 4'd1) begin
                        state_d = ST_INTEGRATE;
                    end
                end
                default: begin
                    state_d = ST_INTEGRATE;
                    mem_d   = RESET_V;
                end
            endcase
        end
        // A disabled cycle always clears the pulse, even if FIRE is being held
        spike_d = ena && (state_d == ST_FIRE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INTEGRATE;
            rcnt_q      <= '0;
            membrane    <= RESET_V;
            spike       <= 1'b0;
            spike_count <= '0;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            membrane    <= mem_d;
            spike       <= spike_d;
            spike_count <= cnt_d;
        end
    end

endmodule

// File: tb/tb_lif_membrane_integrator.sv
// Bench for lif_membrane_integrator: directed vectors, expected values queued by the driver
// and compared by an independent monitor at each falling edge (or on an explicit probe).
// The comparator is modelled here as membrane >= thr, with thr wide enough to be unreachable.
module tb_lif_membrane_integrator;

    logic       clk;
    logic       clk_run;
    logic       rst_n;
    logic       ena;
    logic       in_valid;
    logic [7:0] in_weight;
    logic       in_ready;
    logic       leak_tick;
    logic       cmp_ge;
    logic [7:0] membrane;
    logic       spike;
    logic       refractory;
    logic [7:0] spike_count;
    logic [8:0] thr;

    typedef struct {
        string nm;
        int    m;
        int    s;
        int    r;
        int    y;
        int    c;
    } exp_t;

    exp_t q[$];
    event probe_ev;
    int   n_total;
    int   n_pass;

    assign cmp_ge = ({1'b0, membrane} >= thr);

    lif_membrane_integrator #(
        .WIDTH(8), .LEAK_SHIFT(3), .REFRACT(4), .RESET_V(8'd0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_weight(in_weight),
        .in_ready(in_ready), .leak_tick(leak_tick), .cmp_ge(cmp_ge), .membrane(membrane),
        .spike(spike), .refractory(refractory), .spike_count(spike_count)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    task automatic chk(input string nm, input string fld, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s.%s got %0d want %0d", nm, fld, got, want);
    endtask

    // Monitor: pops one expectation per falling edge (or probe) and compares all outputs
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or probe_ev);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.nm, "membrane",    int'(membrane),    e.m);
                chk(e.nm, "spike",       int'(spike),       e.s);
                chk(e.nm, "refractory",  int'(refractory),  e.r);
                chk(e.nm, "in_ready",    int'(in_ready),    e.y);
                chk(e.nm, "spike_count", int'(spike_count), e.c);
            end
        end
    end

    function automatic exp_t mk(input string nm, input int m, s, r, y, c);
        exp_t x;
        x.nm = nm; x.m = m; x.s = s; x.r = r; x.y = y; x.c = c;
        return x;
    endfunction

    // Drive inputs for the next rising edge and queue the outputs expected after it
    task automatic step(input logic rn, e, v, input logic [7:0] w, input logic lk,
                        input logic [8:0] th, input int em, es, er, ey, ec, input string nm);
        @(negedge clk);
        #1;
        rst_n = rn; ena = e; in_valid = v; in_weight = w; leak_tick = lk; thr = th;
        q.push_back(mk(nm, em, es, er, ey, ec));
    endtask

    initial begin
        int k;
        int ph;
        n_total = 0; n_pass = 0;
        clk_run = 1'b0;
        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_weight = 8'd0; leak_tick = 1'b0;
        thr = 9'd120;

        // Reset with no clock ever toggled
        #3;
        q.push_back(mk("reset", 0, 0, 0, 1, 0));
        ->probe_ev;
        #4;
        rst_n = 1'b1;
        clk_run = 1'b1;

        // Integrate to threshold 120 and fire
        step(1, 1, 1, 8'd50, 0, 9'd120,  50, 0, 0, 1, 0, "w1");
        step(1, 1, 1, 8'd50, 0, 9'd120, 100, 0, 0, 1, 0, "w2");
        step(1, 1, 1, 8'd50, 0, 9'd120, 150, 0, 0, 1, 0, "w3");
        step(1, 1, 1, 8'd50, 0, 9'd120,   0, 1, 1, 0, 1, "fire");
        step(1, 1, 1, 8'd50, 0, 9'd120,   0, 0, 1, 0, 1, "fire_end");
        step(1, 1, 1, 8'd50, 0, 9'd120,   0, 0, 1, 0, 1, "refr3");
        step(1, 1, 1, 8'd50, 0, 9'd120,   0, 0, 1, 0, 1, "refr2");
        step(1, 1, 1, 8'd50, 0, 9'd120,   0, 0, 1, 0, 1, "refr1");
        step(1, 1, 1, 8'd50, 0, 9'd120,   0, 0, 0, 1, 1, "refr_exit");
        step(1, 1, 0, 8'd0,  0, 9'd120,   0, 0, 0, 1, 1, "no_accept");

        // Clamping at both ends (threshold unreachable)
        step(1, 1, 1, 8'd125, 0, 9'd300, 125, 0, 0, 1, 1, "up1");
        step(1, 1, 1, 8'd125, 0, 9'd300, 250, 0, 0, 1, 1, "up2");
        step(1, 1, 1, 8'd20,  0, 9'd300, 255, 0, 0, 1, 1, "sat_hi");
        step(1, 1, 1, 8'h80,  0, 9'd300, 127, 0, 0, 1, 1, "neg128");
        step(1, 1, 1, 8'h8B,  0, 9'd300,  10, 0, 0, 1, 1, "neg117");
        step(1, 1, 1, 8'hE2,  0, 9'd300,   0, 0, 0, 1, 1, "sat_lo");

        // Leak, alone and combined with a weight
        step(1, 1, 1, 8'd100, 0, 9'd300, 100, 0, 0, 1, 1, "up100a");
        step(1, 1, 1, 8'd100, 0, 9'd300, 200, 0, 0, 1, 1, "up100b");
        step(1, 1, 0, 8'd0,   1, 9'd300, 175, 0, 0, 1, 1, "leak");
        step(1, 1, 1, 8'd10,  1, 9'd300, 164, 0, 0, 1, 1, "leak_add");

        // Enable low for three cycles freezes everything
        step(1, 0, 1, 8'd50, 1, 9'd300, 164, 0, 0, 0, 1, "ena_lo1");
        step(1, 0, 1, 8'd50, 1, 9'd300, 164, 0, 0, 0, 1, "ena_lo2");
        step(1, 0, 1, 8'd50, 1, 9'd300, 164, 0, 0, 0, 1, "ena_lo3");
        step(1, 1, 1, 8'd10, 0, 9'd300, 174, 0, 0, 1, 1, "ena_back");

        // Threshold 0: fire, then reset in the middle of the refractory period
        step(1, 1, 0, 8'd0, 0, 9'd0, 0, 1, 1, 0, 2, "fire2");
        step(1, 1, 0, 8'd0, 0, 9'd0, 0, 0, 1, 0, 2, "refr_a");
        step(1, 1, 0, 8'd0, 0, 9'd0, 0, 0, 1, 0, 2, "refr_b");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        q.push_back(mk("async_rst", 0, 0, 0, 1, 0));
        ->probe_ev;
        step(0, 1, 0, 8'd0, 0, 9'd0, 0, 0, 0, 1, 0, "rst_hold");

        // Free-running refire every 6 cycles, count saturates at 255
        for (int i = 1; i <= 1560; i++) begin
            k  = (i - 1) / 6;
            ph = (i - 1) % 6;
            step(1, 1, 0, 8'd0, 0, 9'd0, 0,
                 (ph == 0) ? 1 : 0, (ph < 5) ? 1 : 0, (ph == 5) ? 1 : 0,
                 (k + 1 > 255) ? 255 : k + 1, "refire");
        end

        repeat (4) @(negedge clk);
        #1;
        n_total++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain got %0d pending want 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
